// File: rtl/glip_uart_pkg.sv
// Shared definitions for the GLIP UART backend controllers: state encoding,
// the default escape byte and the credit width helper.
package glip_uart_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_DATA        = 3'd1;
  localparam logic [2:0] ST_DATA_REPEAT = 3'd2;
  localparam logic [2:0] ST_CRED_ESC    = 3'd3;
  localparam logic [2:0] ST_CRED_BYTE   = 3'd4;

  localparam logic [7:0] GLIP_UART_ESC = 8'hFE;

  // Top payload byte carries a forced 1 in bit 0, so one bit per message is lost.
  function automatic int credit_width(input int credit_bytes);
    return 8 * credit_bytes - 1;
  endfunction

endpackage

// File: rtl/glip_uart_control_egress_param_if.sv
// Byte stream between the user egress FIFO, the egress controller and the
// UART transmitter. master = controller side, slave = FIFO/transmitter side.
interface glip_uart_control_egress_param_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_enable;
  logic       out_done;

  modport master (
    input  in_data, in_valid, out_done,
    output in_ready, out_data, out_enable
  );

  modport slave (
    output in_data, in_valid, out_done,
    input  in_ready, out_data, out_enable
  );
endinterface

// File: rtl/glip_uart_control_egress_param.sv
// Egress controller: forwards FIFO bytes to the UART transmitter, doubles the
// escape byte and inserts credit messages (escape + CREDIT_BYTES payload bytes).
//
// state          | meaning
// ST_IDLE        | nothing on the line; pick credit message or user word
// ST_DATA        | user byte on the line
// ST_DATA_REPEAT | second copy of an escaped user byte
// ST_CRED_ESC    | escape marker opening a credit message
// ST_CRED_BYTE   | credit payload byte idx (counts down to 0)
module glip_uart_control_egress_param
  import glip_uart_pkg::*;
#(
  parameter int         CREDIT_BYTES = 2,
  parameter logic [7:0] ESC_BYTE     = GLIP_UART_ESC,
  localparam int        CW           = credit_width(CREDIT_BYTES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  glip_uart_control_egress_param_if.master       bus,
  input  logic                                   can_send,
  output logic                                   transfer,
  input  logic [CW-1:0]                          credit,
  input  logic                                   credit_en,
  output logic                                   credit_ack,
  output logic                                   error
);

  localparam logic [1:0] IDX_TOP = 2'(CREDIT_BYTES - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cred_q, cred_d;
  logic          error_q, error_d;

  logic [7:0] low_byte;
  logic [7:0] out_data_c;
  logic       out_enable_c;
  logic       in_ready_c;
  logic       credit_ack_c;

  if (CREDIT_BYTES > 1) begin : g_low
    assign low_byte = cred_q[{idx_q, 3'b000} +: 8];
  end else begin : g_no_low
    assign low_byte = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cred_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cred_q  <= cred_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cred_d  = cred_q;
    case (state_q)
      ST_IDLE: begin
        if (credit_en) begin
          cred_d  = credit;
          idx_d   = IDX_TOP;
          state_d = ST_CRED_ESC;
        end else if (can_send && bus.in_valid) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.out_done)
          state_d = (bus.in_data == ESC_BYTE) ? ST_DATA_REPEAT : ST_IDLE;
      end
      ST_DATA_REPEAT: begin
        if (bus.out_done) state_d = ST_IDLE;
      end
      ST_CRED_ESC: begin
        if (bus.out_done) state_d = ST_CRED_BYTE;
      end
      ST_CRED_BYTE: begin
        if (bus.out_done) begin
          if (idx_q == 2'd0) state_d = ST_IDLE;
          else               idx_d   = idx_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are held at zero while reset is asserted, independent of state.
  always_comb begin
    out_data_c   = 8'h00;
    out_enable_c = 1'b0;
    in_ready_c   = 1'b0;
    credit_ack_c = 1'b0;
    if (rst) begin
      case (state_q)
        ST_DATA: begin
          out_data_c   = bus.in_data;
          out_enable_c = 1'b1;
          in_ready_c   = bus.out_done && (bus.in_data != ESC_BYTE);
        end
        ST_DATA_REPEAT: begin
          out_data_c   = ESC_BYTE;
          out_enable_c = 1'b1;
          in_ready_c   = bus.out_done;
        end
        ST_CRED_ESC: begin
          out_data_c   = ESC_BYTE;
          out_enable_c = 1'b1;
        end
        ST_CRED_BYTE: begin
          out_data_c   = (idx_q == IDX_TOP) ? {cred_q[CW-1 -: 7], 1'b1} : low_byte;
          out_enable_c = 1'b1;
          credit_ack_c = bus.out_done && (idx_q == 2'd0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    error_d = error_q;
    if (bus.out_done && !out_enable_c) error_d = 1'b1;
    if ((state_q == ST_DATA || state_q == ST_DATA_REPEAT) && !bus.in_valid) error_d = 1'b1;
  end

  assign bus.out_data   = out_data_c;
  assign bus.out_enable = out_enable_c;
  assign bus.in_ready   = in_ready_c;
  assign credit_ack     = credit_ack_c;
  assign transfer       = bus.in_valid & in_ready_c;
  assign error          = error_q;

endmodule

// File: doc/glip_uart_control_egress_param.md
# glip_uart_control_egress_param

Parametrised egress controller for the GLIP UART backend. Sits between the user egress FIFO and the UART transmit module and multiplexes flow-control credit messages into the outgoing byte stream. Occurrences of the escape byte in user data are doubled. Compared with the fixed 15-bit/0xFE controller, this block adds:
- configurable credit width and escape byte;
- a credit value snapshotted for the duration of a message;
- single acknowledgement of escaped words;
- protocol-error detection.

## Interface
Parameters:
- CREDIT_BYTES, 2: credit payload bytes after the marker byte; credit width CW = 8*CREDIT_BYTES-1; legal 1..4.
- ESC_BYTE, 8'hFE: escape/control indicator; bit 0 must be 0.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-low.
- in_data  in  8  user byte from FIFO.
- in_valid  in  1  user byte available.
- in_ready  out  1  user byte consumed this cycle.
- out_data  out  8  byte to transmitter.
- out_enable  out  1  transmit request; out_data stable while high.
- out_done  in  1  one-cycle pulse: current byte sent.
- can_send  in  1  remote side has credit for a user word.
- transfer  out  1  pulse per accepted user word (in_valid & in_ready).
- credit  in  CW  credit value to advertise.
- credit_en  in  1  credit message requested.
- credit_ack  out  1  pulse: credit message fully sent.
- error  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, DATA, DATA_REPEAT, CRED_ESC, CRED_BYTE. CRED_BYTE uses a byte index idx counting CREDIT_BYTES-1 down to 0.
- IDLE:
  - If credit_en: latch credit into cred_q, set idx = CREDIT_BYTES-1, go to CRED_ESC. Credit has priority over data.
  - Else if can_send & in_valid: go to DATA.
  - No outputs are asserted in IDLE.
- DATA: out_data = in_data, out_enable = 1. On out_done:
  - if in_data == ESC_BYTE, go to DATA_REPEAT without asserting in_ready;
  - otherwise assert in_ready and go to IDLE.
- DATA_REPEAT: out_data = ESC_BYTE, out_enable = 1; can_send is not sampled. On out_done: in_ready = 1, go to IDLE. Each escaped word is acknowledged exactly once.
- CRED_ESC: out_data = ESC_BYTE, out_enable = 1. On out_done, go to CRED_BYTE.
- CRED_BYTE: byte content by idx.
  - idx = CREDIT_BYTES-1: out_data = {cred_q[CW-1 -: 7], 1'b1}. Bit 0 = 1, so this byte never equals ESC_BYTE.
  - Lower idx: out_data = cred_q[8*idx+7 : 8*idx].
  - On out_done with idx > 0: decrement idx.
  - On out_done with idx == 0: credit_ack = 1, go to IDLE.
- cred_q is held for the whole message; changes to credit mid-message have no effect.
- error is set and stays set until reset when:
  - out_done is seen while out_enable = 0; or
  - in_valid falls while in DATA or DATA_REPEAT.
- transfer = in_valid & in_ready; no pulses for control bytes.

## Timing
- Reset (rst = 0 at a clk edge): state = IDLE, idx = 0, cred_q = 0, error = 0.
- Combinational outputs forced to 0 during reset: in_ready, out_enable, credit_ack, transfer. out_data = 8'h00.
- out_data, out_enable, in_ready, credit_ack and transfer are combinational from state and inputs.
- Minimum user byte spacing is one IDLE cycle plus the transmitter time: DATA is entered the cycle after IDLE.
- Credit message length is CREDIT_BYTES+1 out_done pulses. credit_ack falls in the same cycle as the last out_done.
- credit_en asserted during a user word is serviced at the next IDLE. A credit message never splits an escaped pair.
- credit_en held high after credit_ack starts a new message from IDLE with a freshly latched credit.
- Reset mid-message abandons the message. Reset mid-escape leaves the in-flight FIFO word unacknowledged.

## Structure
- Shared package glip_uart_pkg:
  - state encoding localparams (3-bit);
  - default escape value GLIP_UART_ESC = 8'hFE;
  - function computing CW from CREDIT_BYTES.
- No sub-module; single FSM plus cred_q/idx registers, about 150-250 lines of RTL.

## Test plan
- Defaults, in_data 0x41, can_send = 1, out_done 3 cycles after out_enable -> exactly one byte 0x41, one transfer pulse, in_ready high for one cycle.
- in_data 0xFE -> bytes 0xFE, 0xFE; a single in_ready/transfer pulse, coincident with the second out_done.
- credit = 15'h1234, credit_en -> bytes 0xFE, 0x25, 0x34; credit_ack on the third out_done. Change credit to 0x7FFF after the first byte; output bytes remain unchanged.
- CREDIT_BYTES = 3, credit = 23'h7ABCDE -> bytes 0xFE, 0xF5, 0xBC, 0xDE.
- credit_en and in_valid rise together in IDLE -> credit message sent first, then the user byte. With can_send = 0 the user byte is never sent.
- Spurious out_done in IDLE -> error = 1 and held. rst = 0 for one cycle mid CRED_BYTE -> IDLE, error = 0, out_enable = 0 in the following cycle.
